bnn_result_writer: RTL and testbench

Downstream writeback stage for BNNCore. It samples the 32-bit binarised result bus on every cycle the core asserts its store control bit and buffers the words in a FIFO. It then drains them to the layer activation memory through a valid/ready write port with an auto-incrementing address. A layer's output is collected as one job: start, fixed word count, done pulse.

---
 rtl/bnn_result_writer.sv | 183 ++++++++++++++++++
 tb/tb_bnn_result_writer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_result_writer.sv
// Result writeback stage: captures core result words into a show-ahead FIFO and drains
// them to activation memory with an auto-incrementing address. Optional macro: BNN_WB_CHECKSUM_EN.
module bnn_result_writer #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              store_in,
    input  logic [31:0]       result_bins,
    input  logic              cfg_start,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [CNT_W-1:0]  cfg_word_count,
    output logic              mem_wr_valid,
    input  logic              mem_wr_ready,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [31:0]       mem_wr_data,
    output logic              busy,
    output logic              done,
    output logic              overflow
`ifdef BNN_WB_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FILL_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] FILL_FULL = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [31:0]       mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    fill;
    logic [PTR_W:0]    fill_nxt;
    logic [CNT_W-1:0]  target;
    logic [CNT_W-1:0]  captured;
    logic              full;
    logic              pop;
    logic              store_run;
    logic              push;
    logic              drop;
    logic              last_store;
    logic [31:0]       head_nxt;

    // Handshake, FIFO occupancy, next state and next show-ahead head word
    always_comb begin
        full       = (fill == FILL_FULL);
        pop        = mem_wr_valid && mem_wr_ready;
        store_run  = (state == S_RUN) && store_in;
        push       = store_run && (!full || pop);
        drop       = store_run && full && !pop;
        last_store = store_run && ((captured + CNT_W'(1)) == target);

        case ({push, pop})
            2'b10:   fill_nxt = fill + FILL_ONE;
            2'b01:   fill_nxt = fill - FILL_ONE;
            default: fill_nxt = fill;
        endcase

        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cfg_start) begin
                    state_nxt = (cfg_word_count == '0) ? S_DONE : S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_store) begin
                    state_nxt = S_DRAIN;
                end else begin
                    state_nxt = S_RUN;
                end
            end
            S_DRAIN: begin
                if (fill == '0) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // Head after this edge: next stored word, or the incoming word when the FIFO runs dry
        head_nxt = mem_wr_data;
        if (pop) begin
            if (fill > FILL_ONE) begin
                head_nxt = mem[rd_ptr + PTR_W'(1)];
            end else if (push) begin
                head_nxt = result_bins;
            end else begin
                head_nxt = mem_wr_data;
            end
        end else if (fill == '0) begin
            if (push) begin
                head_nxt = result_bins;
            end else begin
                head_nxt = mem_wr_data;
            end
        end else begin
            head_nxt = mem[rd_ptr];
        end
    end

    // FIFO storage array
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= result_bins;
        end
    end

    // Job FSM, FIFO pointers and registered write-port/status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            fill         <= '0;
            target       <= '0;
            captured     <= '0;
            mem_wr_valid <= 1'b0;
            mem_wr_addr  <= '0;
            mem_wr_data  <= 32'h0000_0000;
            busy         <= 1'b0;
            done         <= 1'b0;
            overflow     <= 1'b0;
`ifdef BNN_WB_CHECKSUM_EN
            checksum     <= 32'h0000_0000;
`endif
        end else begin
            state <= state_nxt;
            fill  <= fill_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if ((state == S_IDLE) && cfg_start) begin
                mem_wr_addr <= cfg_base_addr;
                target      <= cfg_word_count;
                captured    <= '0;
                overflow    <= 1'b0;
`ifdef BNN_WB_CHECKSUM_EN
                checksum    <= 32'h0000_0000;
`endif
            end else begin
                if (pop) begin
                    mem_wr_addr <= mem_wr_addr + ADDR_W'(1);
`ifdef BNN_WB_CHECKSUM_EN
                    checksum    <= checksum ^ mem_wr_data;
`endif
                end
                // Dropped words still count toward the job length
                if (store_run) begin
                    captured <= captured + CNT_W'(1);
                end
                if (drop) begin
                    overflow <= 1'b1;
                end
            end
            mem_wr_data  <= head_nxt;
            mem_wr_valid <= ((state_nxt == S_RUN) || (state_nxt == S_DRAIN)) && (fill_nxt != '0);
            busy         <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
            done         <= (state_nxt == S_DONE);
        end
    end

endmodule

// File: tb/tb_bnn_result_writer.sv
// Scoreboard bench for bnn_result_writer: a transaction model predicts the accepted words,
// their addresses and the overflow flag; an independent monitor checks every memory write.
module tb_bnn_result_writer;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 10;
    localparam int CNT_W  = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              store_in;
    logic [31:0]       result_bins;
    logic              cfg_start;
    logic [ADDR_W-1:0] cfg_base_addr;
    logic [CNT_W-1:0]  cfg_word_count;
    logic              mem_wr_valid;
    logic              mem_wr_ready;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [31:0]       mem_wr_data;
    logic              busy;
    logic              done;
    logic              overflow;
`ifdef BNN_WB_CHECKSUM_EN
    logic [31:0]       checksum;
`endif

    bnn_result_writer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .store_in       (store_in),
        .result_bins    (result_bins),
        .cfg_start      (cfg_start),
        .cfg_base_addr  (cfg_base_addr),
        .cfg_word_count (cfg_word_count),
        .mem_wr_valid   (mem_wr_valid),
        .mem_wr_ready   (mem_wr_ready),
        .mem_wr_addr    (mem_wr_addr),
        .mem_wr_data    (mem_wr_data),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow)
`ifdef BNN_WB_CHECKSUM_EN
        ,
        .checksum       (checksum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    int          n_cmp  = 0;
    int          n_fail = 0;
    wr_t         exp_q[$];
    logic [31:0] dir_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted write must match the scoreboard head; stalls must hold
    initial begin
        logic              stalled;
        logic [ADDR_W-1:0] p_addr;
        logic [31:0]       p_data;
        wr_t               e;
        stalled = 1'b0;
        p_addr  = '0;
        p_data  = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("stall_valid", 32'(mem_wr_valid), 32'd1);
                    check("stall_addr", 32'(mem_wr_addr), 32'(p_addr));
                    check("stall_data", mem_wr_data, p_data);
                end
                if (mem_wr_valid && mem_wr_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_write: addr 0x%03h data 0x%08h, none expected at %0t",
                                 mem_wr_addr, mem_wr_data, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("write_addr", 32'(mem_wr_addr), 32'(e.addr));
                        check("write_data", mem_wr_data, e.data);
                    end
                end
                stalled = mem_wr_valid && !mem_wr_ready;
                p_addr  = mem_wr_addr;
                p_data  = mem_wr_data;
            end
        end
    end

    // One job: model decides which stores are kept (FIFO of DEPTH, one pop per ready cycle)
    task automatic run_job(input logic [ADDR_W-1:0] base, input int count, input int store_pct,
                           input int ready_pct, input int stall, input bit poke);
        int          occ = 0;
        int          acc = 0;
        int          cap = 0;
        int          c   = 0;
        bit          ovf = 1'b0;
        bit          got = 1'b0;
        bit          st;
        bit          rd;
        bit          pop;
        logic [31:0] w;
        logic [31:0] cks = 32'h0;
        cfg_base_addr  = base;
        cfg_word_count = CNT_W'(count);
        cfg_start      = 1'b1;
        store_in       = 1'b0;
        mem_wr_ready   = 1'b0;
        step();
        cfg_start = 1'b0;
        if (count == 0) begin
            @(negedge clk);
            check("zero_count_done", 32'(done), 32'd1);
            got = 1'b1;
        end else begin
            while (cap < count && c < 4000) begin
                st  = ($urandom_range(0, 99) < store_pct);
                rd  = (c >= stall) && ($urandom_range(0, 99) < ready_pct);
                pop = (occ > 0) && rd;
                w   = $urandom;
                if (st) begin
                    if (dir_q.size() != 0) w = dir_q.pop_front();
                    cap++;
                    if (occ < DEPTH || pop) begin
                        exp_q.push_back('{ADDR_W'(int'(base) + acc), w});
                        acc++;
                        cks ^= w;
                        occ++;
                    end else begin
                        ovf = 1'b1;
                    end
                end
                if (pop) occ--;
                store_in     = st;
                result_bins  = w;
                mem_wr_ready = rd;
                if (poke && c == 1) begin
                    cfg_start      = 1'b1;
                    cfg_base_addr  = ADDR_W'($urandom);
                    cfg_word_count = CNT_W'($urandom);
                end else begin
                    cfg_start = 1'b0;
                end
                step();
                c++;
            end
            store_in  = 1'b0;
            cfg_start = 1'b0;
            for (int k = 0; k < 400 && !got; k++) begin
                mem_wr_ready = (c >= stall) && ($urandom_range(0, 99) < ready_pct);
                result_bins  = $urandom;
                @(negedge clk);
                if (done) begin
                    got = 1'b1;
                end else begin
                    step();
                    c++;
                end
            end
        end
        check("done_seen", 32'(got), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        check("overflow", 32'(overflow), 32'(ovf));
        check("pending_writes", 32'(exp_q.size()), 32'd0);
`ifdef BNN_WB_CHECKSUM_EN
        check("checksum", checksum, cks);
`endif
        step();
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_valid", 32'(mem_wr_valid), 32'd0);
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        store_in       = 1'b0;
        result_bins    = 32'h0;
        cfg_start      = 1'b0;
        cfg_base_addr  = '0;
        cfg_word_count = '0;
        mem_wr_ready   = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("rst_valid", 32'(mem_wr_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_addr", 32'(mem_wr_addr), 32'd0);
        check("rst_data", mem_wr_data, 32'h0);
        step();
        rst = 1'b0;
        step();

        // Basic job with the four fixed words
        dir_q = '{32'hA5A5A5A5, 32'h00000001, 32'hFFFFFFFF, 32'h12345678};
        run_job(10'h010, 4, 100, 100, 0, 1'b0);
`ifdef BNN_WB_CHECKSUM_EN
        check("basic_checksum", checksum, 32'h486E0C23);
`endif
        run_job(10'h123, 3, 100, 100, 13, 1'b0);   // long backpressure
        run_job(10'h200, 10, 100, 100, 12, 1'b0);  // overflow: two stores dropped
        run_job(10'h080, 10, 100, 100, 8, 1'b0);   // full FIFO with push and pop together
        run_job(10'h155, 0, 100, 100, 0, 1'b0);    // empty job
        run_job(10'h3FE, 3, 100, 100, 0, 1'b0);    // address wrap
        run_job(10'h040, 6, 70, 60, 2, 1'b1);      // start pulse while running
        for (int j = 0; j < 20; j++) begin
            run_job(ADDR_W'($urandom), int'($urandom_range(0, 20)), int'($urandom_range(30, 100)),
                    int'($urandom_range(20, 100)), int'($urandom_range(0, 15)), 1'($urandom));
        end

        // Reset while draining three queued words
        cfg_base_addr  = 10'h100;
        cfg_word_count = 10'd3;
        cfg_start      = 1'b1;
        mem_wr_ready   = 1'b0;
        step();
        cfg_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            store_in    = 1'b1;
            result_bins = $urandom;
            step();
        end
        store_in = 1'b0;
        @(negedge clk);
        check("drain_busy", 32'(busy), 32'd1);
        check("drain_valid", 32'(mem_wr_valid), 32'd1);
        step();
        rst = 1'b1;
        step();
        rst          = 1'b0;
        mem_wr_ready = 1'b1;
        @(negedge clk);
        check("midrst_valid", 32'(mem_wr_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 5; i++) begin
            check("midrst_no_done", 32'(done), 32'd0);
            step();
            @(negedge clk);
        end
        check("midrst_still_idle", 32'(mem_wr_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
